// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Constants and types shared by the node-memory port arbiter and the
//   clients of the node memory (2048 x 16-bit words).
//   Contents: memory geometry, arbiter FSM state encoding, the
//   internal-flags word address, and an index-width helper.
package mem_port_arbiter_pkg;

    localparam int MEM_DEPTH = 2048;
    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 16;

    // Word that holds the node's internal protocol flags.
    localparam logic [ADDR_W-1:0] FLAGS_ADDR = 11'h001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    // Width of an index into n items; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the requester-side and memory-side signals of the node-memory
//   port arbiter.
//   slave  : arbiter view (requests and memory read data in, grants and
//            memory command out).
//   master : environment view (requesters plus memory model).
//   Signals: en, req, req_addr, req_wdata, req_we (flattened per requester),
//            gnt, mem_addr, mem_wdata, mem_wr_en, mem_rdata, rd_data,
//            rd_valid, busy, timeout, timeout_id.
interface mem_port_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = mem_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W = mem_port_arbiter_pkg::DATA_W
);
    logic                      en;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*ADDR_W-1:0]   req_addr;
    logic [N_REQ*DATA_W-1:0]   req_wdata;
    logic [N_REQ-1:0]          req_we;
    logic [N_REQ-1:0]          gnt;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_wr_en;
    logic [DATA_W-1:0]         mem_rdata;
    logic [DATA_W-1:0]         rd_data;
    logic [N_REQ-1:0]          rd_valid;
    logic                      busy;
    logic                      timeout;
    logic [2:0]                timeout_id;

    modport slave (
        input  en, req, req_addr, req_wdata, req_we, mem_rdata,
        output gnt, mem_addr, mem_wdata, mem_wr_en, rd_data, rd_valid,
               busy, timeout, timeout_id
    );

    modport master (
        output en, req, req_addr, req_wdata, req_we, mem_rdata,
        input  gnt, mem_addr, mem_wdata, mem_wr_en, rd_data, rd_valid,
               busy, timeout, timeout_id
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector, reusable by any scheduler.
//   Searches the eligible mask upward from ptr with wrap-around and returns
//   the first hit as a one-hot vector and as an index.
//   Ports: eligible (N), ptr (IDX_W) in; winner_oh (N), winner_idx (IDX_W),
//          found out.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             found
);

    always_comb begin
        int cand;
        cand       = 0;
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!found && eligible[cand]) begin
                found            = 1'b1;
                winner_oh[cand]  = 1'b1;
                winner_idx       = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin, burst-locked arbiter for the single node-memory port.
//   A requester keeps the port while it holds req; a hold counter revokes
//   the grant after MAX_HOLD cycles and blocks that requester until it
//   drops req. Read data (1-cycle memory latency) is steered back with a
//   registered one-hot rd_valid.
//   Ports: clk, nrst (async, active-low), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = mem_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W   = mem_port_arbiter_pkg::DATA_W,
    parameter int MAX_HOLD = 64,
    parameter int HOLD_W   = 7
) (
    input logic               clk,
    input logic               nrst,
    mem_port_arbiter_if.slave bus
);
    import mem_port_arbiter_pkg::*;

    localparam int                IDX_W      = idx_width(N_REQ);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_REQ - 1);
    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    arb_state_e         state_q,    state_d;
    logic [N_REQ-1:0]   gnt_q,      gnt_d;
    logic [IDX_W-1:0]   owner_q,    owner_d;
    logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]   blocked_q,  blocked_d;
    logic [N_REQ-1:0]   rd_valid_q, rd_valid_d;
    logic               timeout_q,  timeout_d;
    logic [2:0]         timeout_id_q, timeout_id_d;

    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [IDX_W-1:0]   next_ptr;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .eligible   (bus.req & ~blocked_q),
        .ptr        (rr_ptr_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    // Pointer moves just past whoever leaves the port.
    assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            hold_cnt_q   <= '0;
            blocked_q    <= '0;
            rd_valid_q   <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            blocked_q    <= blocked_d;
            rd_valid_q   <= rd_valid_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;
        // A blocked requester is released as soon as it is seen idle.
        blocked_d    = blocked_q & bus.req;
        // Every granted read cycle, including the last one, returns data.
        rd_valid_d   = gnt_q & ~bus.req_we;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.en && pick_found) begin
                    state_d    = ST_OWN;
                    gnt_d      = pick_oh;
                    owner_d    = pick_idx;
                    hold_cnt_d = HOLD_W'(1);
                end
            end
            ST_OWN: begin
                // Release is checked first so it wins over a coincident timeout.
                if (!bus.req[owner_q]) begin
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                    rr_ptr_d   = next_ptr;
                end else if (hold_cnt_q == MAX_HOLD_C) begin
                    state_d            = ST_IDLE;
                    gnt_d              = '0;
                    hold_cnt_d         = '0;
                    rr_ptr_d           = next_ptr;
                    timeout_d          = 1'b1;
                    timeout_id_d       = 3'(owner_q);
                    blocked_d[owner_q] = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory command follows the owner combinationally, so an async reset
    // removes it without waiting for a clock.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wr_en = 1'b0;
        if (state_q == ST_OWN) begin
            bus.mem_addr  = bus.req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
            bus.mem_wdata = bus.req_wdata[int'(owner_q)*DATA_W +: DATA_W];
            bus.mem_wr_en = bus.req_we[owner_q];
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.busy       = |gnt_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = bus.mem_rdata;
    assign bus.timeout    = timeout_q;
    assign bus.timeout_id = timeout_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int AW   = 11;
    localparam int DW   = 16;
    localparam int MAXH = 8;
    localparam int HW   = 4;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .N_REQ    (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_HOLD (MAXH),
        .HOLD_W   (HW)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem    [MEM_DEPTH];
    logic [DW-1:0] shadow [MEM_DEPTH];

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 1) return 16'h0080;
        return DW'((a * 40503) ^ 16'h5a5a);
    endfunction

    // Node memory: 1-cycle read latency, write on mem_wr_en.
    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = init_word(i);
        bus.mem_rdata <= '0;
        forever begin
            @(posedge clk);
            bus.mem_rdata <= mem[bus.mem_addr];
            if (bus.mem_wr_en) mem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Stimulus
    logic [N-1:0]  req_v, we_v;
    logic          en_v;
    logic [AW-1:0] addr_v  [N];
    logic [DW-1:0] wdata_v [N];

    // Reference model state (owner -1 means port free)
    int            m_owner, m_ptr, m_hold, m_toid;
    logic [N-1:0]  m_blocked, m_rdv;
    logic [DW-1:0] m_rdexp;
    logic          m_to;

    task automatic drive();
        bus.en     = en_v;
        bus.req    = req_v;
        bus.req_we = we_v;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = addr_v[i];
            bus.req_wdata[i*DW +: DW] = wdata_v[i];
        end
        #1;
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_hold = 0; m_toid = 0;
        m_blocked = '0; m_rdv = '0; m_rdexp = '0; m_to = 1'b0;
    endtask

    task automatic model_step();
        int n_owner, n_ptr, n_hold, c;
        logic [N-1:0] n_blk, n_rdv;
        logic n_to;
        n_owner = m_owner; n_ptr = m_ptr; n_hold = m_hold;
        n_rdv = '0; n_to = 1'b0; c = 0;
        n_blk = m_blocked & req_v;
        if (m_owner >= 0) begin
            if (!we_v[m_owner]) begin
                n_rdv[m_owner] = 1'b1;
                m_rdexp = shadow[addr_v[m_owner]];
            end else begin
                shadow[addr_v[m_owner]] = wdata_v[m_owner];
            end
            if (!req_v[m_owner]) begin
                n_owner = -1; n_hold = 0; n_ptr = (m_owner + 1) % N;
            end else if (m_hold == MAXH) begin
                n_owner = -1; n_hold = 0; n_ptr = (m_owner + 1) % N;
                n_to = 1'b1; m_toid = m_owner; n_blk[m_owner] = 1'b1;
            end else begin
                n_hold = m_hold + 1;
            end
        end else if (en_v) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (n_owner < 0 && req_v[c] && !m_blocked[c]) begin
                    n_owner = c; n_hold = 1;
                end
            end
        end
        m_owner = n_owner; m_ptr = n_ptr; m_hold = n_hold;
        m_blocked = n_blk; m_rdv = n_rdv; m_to = n_to;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_v = '0; we_v = '0; en_v = 1'b1;
        for (int i = 0; i < N; i++) begin addr_v[i] = '0; wdata_v[i] = '0; end
    endtask

    task automatic do_reset();
        idle_inputs();
        drive();
        nrst = 1'b0;
        @(posedge clk);
        #2;
        nrst = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        req_v = '1; we_v = '1; en_v = 1'b1;
        for (int i = 0; i < N; i++) begin addr_v[i] = AW'(i + 3); wdata_v[i] = DW'(i + 9); end
        drive();
        @(posedge clk); @(posedge clk); #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.rd_valid !== 4'b0000) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0000", bus.rd_valid); end
        checks++; if (bus.mem_addr !== 11'h000) begin errors++; $display("FAIL reset_mem_addr got=%h exp=000", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0000", bus.mem_wdata); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_mem_wr_en got=%b exp=0", bus.mem_wr_en); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
        checks++; if (bus.timeout_id !== 3'd0) begin errors++; $display("FAIL reset_timeout_id got=%0d exp=0", bus.timeout_id); end
        do_reset();
    endtask

    task automatic test_single_read();
        req_v = 4'b0001; we_v = '0; addr_v[0] = 11'h001;
        drive();
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL read_gnt got=%b exp=0001", bus.gnt); end
        checks++; if (bus.mem_addr !== 11'h001) begin errors++; $display("FAIL read_mem_addr got=%h exp=001", bus.mem_addr); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL read_busy got=%b exp=1", bus.busy); end
        req_v = '0;
        drive();
        tick();
        checks++; if (bus.rd_valid !== 4'b0001) begin errors++; $display("FAIL read_rd_valid got=%b exp=0001", bus.rd_valid); end
        checks++; if (bus.rd_data !== 16'h0080) begin errors++; $display("FAIL read_rd_data got=%h exp=0080", bus.rd_data); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL read_release got=%b exp=0000", bus.gnt); end
        tick();
        checks++; if (bus.rd_valid !== 4'b0000) begin errors++; $display("FAIL read_rd_valid_clear got=%b exp=0000", bus.rd_valid); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] pat [12] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                  4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
        int cnt [N];
        do_reset();
        for (int i = 0; i < N; i++) begin cnt[i] = 0; addr_v[i] = AW'(16 + i); end
        req_v = '1; we_v = '0;
        drive();
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if (bus.gnt !== pat[c]) begin errors++; $display("FAIL rr_order cyc=%0d got=%b exp=%b", c, bus.gnt, pat[c]); end
            for (int i = 0; i < N; i++) begin
                if (bus.gnt[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 2) req_v[i] = 1'b0;
                end
            end
            drive();
        end
        req_v = 4'b1001;
        drive();
        tick();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rr_wrap got=%b exp=0001", bus.gnt); end
        req_v = '0;
        drive();
        tick();
        tick();
    endtask

    task automatic test_write();
        req_v = 4'b0010; we_v = 4'b0010; addr_v[1] = 11'h001; wdata_v[1] = 16'h0040;
        drive();
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL wr_pre_grant got=%b exp=0", bus.mem_wr_en); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL wr_gnt cyc=%0d got=%b exp=0010", c, bus.gnt); end
            checks++; if (bus.mem_wr_en !== 1'b1) begin errors++; $display("FAIL wr_en cyc=%0d got=%b exp=1", c, bus.mem_wr_en); end
            checks++; if (bus.mem_wdata !== 16'h0040) begin errors++; $display("FAIL wr_wdata cyc=%0d got=%h exp=0040", c, bus.mem_wdata); end
            checks++; if (bus.mem_addr !== 11'h001) begin errors++; $display("FAIL wr_addr cyc=%0d got=%h exp=001", c, bus.mem_addr); end
            checks++; if (bus.rd_valid !== 4'b0000) begin errors++; $display("FAIL wr_rd_valid cyc=%0d got=%b exp=0000", c, bus.rd_valid); end
        end
        req_v = '0;
        drive();
        tick();
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL wr_en_after got=%b exp=0", bus.mem_wr_en); end
        checks++; if (bus.rd_valid !== 4'b0000) begin errors++; $display("FAIL wr_rd_valid_after got=%b exp=0000", bus.rd_valid); end
        req_v = 4'b0010; we_v = '0;
        drive();
        tick();
        req_v = '0;
        drive();
        tick();
        checks++; if (bus.rd_valid !== 4'b0010) begin errors++; $display("FAIL wr_readback_valid got=%b exp=0010", bus.rd_valid); end
        checks++; if (bus.rd_data !== 16'h0040) begin errors++; $display("FAIL wr_readback_data got=%h exp=0040", bus.rd_data); end
        tick();
    endtask

    task automatic test_timeout();
        int gcnt, first_g, last_g, to_cnt, to_cyc, to_id, tie_to;
        gcnt = 0; first_g = -1; last_g = -1; to_cnt = 0; to_cyc = -1; to_id = -1; tie_to = 0;
        req_v = 4'b0100; we_v = '0; addr_v[2] = 11'h005;
        drive();
        for (int c = 0; c < 24; c++) begin
            tick();
            if (bus.gnt[2]) begin
                gcnt++;
                if (first_g < 0) first_g = c;
                last_g = c;
            end
            if (bus.timeout) begin to_cnt++; to_cyc = c; to_id = int'(bus.timeout_id); end
        end
        checks++; if (gcnt != MAXH) begin errors++; $display("FAIL to_grant_len got=%0d exp=%0d", gcnt, MAXH); end
        checks++; if (last_g - first_g != MAXH - 1) begin errors++; $display("FAIL to_grant_span got=%0d..%0d exp=contiguous", first_g, last_g); end
        checks++; if (to_cnt != 1) begin errors++; $display("FAIL to_pulses got=%0d exp=1", to_cnt); end
        checks++; if (to_cyc != last_g + 1) begin errors++; $display("FAIL to_pulse_cycle got=%0d exp=%0d", to_cyc, last_g + 1); end
        checks++; if (to_id != 2) begin errors++; $display("FAIL to_id got=%0d exp=2", to_id); end
        checks++; if (bus.timeout_id !== 3'd2) begin errors++; $display("FAIL to_id_hold got=%0d exp=2", bus.timeout_id); end
        req_v = '0;
        drive();
        tick();
        req_v = 4'b0100;
        drive();
        tick();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL to_regrant got=%b exp=0100", bus.gnt); end
        for (int c = 0; c < MAXH - 1; c++) begin
            tick();
            if (bus.timeout) tie_to++;
        end
        req_v = '0;
        drive();
        tick();
        if (bus.timeout) tie_to++;
        checks++; if (tie_to != 0) begin errors++; $display("FAIL tie_timeout got=%0d pulses exp=0", tie_to); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL tie_release got=%b exp=0000", bus.gnt); end
        tick();
    endtask

    task automatic test_enable();
        int stray;
        stray = 0;
        en_v = 1'b0; req_v = 4'b0110; we_v = '0; addr_v[1] = 11'h009; addr_v[2] = 11'h00a;
        drive();
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.gnt !== 4'b0000) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL en_low_grants got=%0d cycles exp=0", stray); end
        en_v = 1'b1;
        drive();
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL en_rise_gnt got=%b exp=0010", bus.gnt); end
        en_v = 1'b0;
        drive();
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL en_low_keep got=%b exp=0010", bus.gnt); end
        req_v = '0; en_v = 1'b1;
        drive();
        tick();
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL en_release got=%b exp=0000", bus.gnt); end
        tick();
    endtask

    task automatic test_async_reset();
        req_v = 4'b1000; we_v = 4'b1000; addr_v[3] = 11'h007; wdata_v[3] = 16'h1234;
        drive();
        tick();
        checks++; if (bus.mem_wr_en !== 1'b1) begin errors++; $display("FAIL ar_wr_active got=%b exp=1", bus.mem_wr_en); end
        #2;
        nrst = 1'b0;
        #1;
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL ar_wr_en got=%b exp=0", bus.mem_wr_en); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL ar_gnt got=%b exp=0000", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b exp=0", bus.busy); end
        model_reset();
        @(posedge clk);
        #1;
        req_v = 4'b1010; we_v = '0;
        drive();
        nrst = 1'b1;
        #1;
        tick();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL ar_first_grant got=%b exp=0010", bus.gnt); end
        req_v = '0;
        drive();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (req_v[i]) begin
                    if ($urandom_range(0, 4) == 0) req_v[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_v[i] = 1'b1;
                end
                we_v[i]    = 1'($urandom_range(0, 1));
                addr_v[i]  = AW'($urandom_range(0, 15));
                wdata_v[i] = DW'($urandom);
            end
            en_v = ($urandom_range(0, 7) != 0);
            drive();
            eg = '0; ea = '0; ed = '0; ew = 1'b0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1; ea = addr_v[m_owner]; ed = wdata_v[m_owner]; ew = we_v[m_owner];
            end
            checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, eg); end
            checks++; if (bus.busy !== (|eg)) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, |eg); end
            checks++; if (bus.mem_addr !== ea) begin errors++; $display("FAIL rand_mem_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_addr, ea); end
            checks++; if (bus.mem_wdata !== ed) begin errors++; $display("FAIL rand_mem_wdata cyc=%0d got=%h exp=%h", cyc, bus.mem_wdata, ed); end
            checks++; if (bus.mem_wr_en !== ew) begin errors++; $display("FAIL rand_mem_wr_en cyc=%0d got=%b exp=%b", cyc, bus.mem_wr_en, ew); end
            checks++; if (bus.rd_valid !== m_rdv) begin errors++; $display("FAIL rand_rd_valid cyc=%0d got=%b exp=%b", cyc, bus.rd_valid, m_rdv); end
            checks++; if (bus.timeout !== m_to) begin errors++; $display("FAIL rand_timeout cyc=%0d got=%b exp=%b", cyc, bus.timeout, m_to); end
            checks++; if (bus.timeout_id !== 3'(m_toid)) begin errors++; $display("FAIL rand_timeout_id cyc=%0d got=%0d exp=%0d", cyc, bus.timeout_id, m_toid); end
            if (m_rdv != '0) begin
                checks++; if (bus.rd_data !== m_rdexp) begin errors++; $display("FAIL rand_rd_data cyc=%0d got=%h exp=%h", cyc, bus.rd_data, m_rdexp); end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) shadow[i] = init_word(i);
        model_reset();
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_timeout();
        test_enable();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
